button_debounce_led: RTL and testbench
======================================

// Module: button_debounce_led
// PURPOSE
//  Conditions the raw iCEBreaker user-button pin into a clean, debounced level and one-cycle
//  press/release pulses, then drives EXTERNAL_LED from that clean signal.
//  It is the input-side front end placed between the button pad and all LED logic.
//  It replaces direct button->LED wiring, which passes bounce and metastability straight to the pin.
// PARAMETERS
//  DEBOUNCE_CYCLES  120000  consecutive stable synced samples required to accept a change (10 ms @ 12 MHz)
//  CNT_W            17      debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//  LED_MODE         1       0: LED follows clean level; 1: LED toggles on each accepted press
//  PCOUNT_W         8       width of press counter
// PORTS
//  CLK            input   1         system clock, 12 MHz
//  RST_N          input   1         asynchronous active-low reset
//  button         input   1         raw pad, active-high, asynchronous to CLK, bouncy
//  button_clean   output  1         debounced level
//  press_pulse    output  1         1-cycle pulse on accepted 0->1
//  release_pulse  output  1         1-cycle pulse on accepted 1->0
//  press_count    output  PCOUNT_W  number of accepted presses, wraps modulo 2**PCOUNT_W
//  EXTERNAL_LED   output  1         LED drive, active-high
// BEHAVIOUR
//  Reset (async assert, sync release): sync flops=0, state=LOW_STABLE, counter=0,
//   button_clean=0, press_pulse=0, release_pulse=0, press_count=0, EXTERNAL_LED=0.
//  Synchroniser: 2 flops, button -> s0 -> s1; only s1 is used downstream.
//  FSM (4 states, registered):
//   LOW_STABLE : s1=1 -> LOW_WAIT, counter<=1; else stay, counter<=0.
//   LOW_WAIT   : s1=0 -> LOW_STABLE, counter<=0 (glitch rejected, no pulse).
//                s1=1 and counter==DEBOUNCE_CYCLES-1 -> HIGH_STABLE; button_clean<=1; press_pulse<=1.
//                otherwise counter<=counter+1.
//   HIGH_STABLE / HIGH_WAIT: mirror images with s1 polarity inverted; acceptance sets
//                button_clean<=0 and release_pulse<=1.
//  Acceptance requires exactly DEBOUNCE_CYCLES consecutive cycles of the new s1 value.
//   Any single opposite sample restarts the count from zero.
//  Latency: raw edge -> button_clean/pulse = 2 (sync) + DEBOUNCE_CYCLES cycles.
//  Pulses: high for exactly one cycle; press and release are never high in the same cycle.
//  press_count: increments in the cycle press_pulse is high; 2**PCOUNT_W-1 wraps to 0.
//  LED: LED_MODE=0 -> EXTERNAL_LED = button_clean (registered copy, +1 cycle).
//       LED_MODE=1 -> EXTERNAL_LED toggles in the cycle after press_pulse; releases ignored.
//  Counter never exceeds DEBOUNCE_CYCLES-1, so there is no overflow path.
//  Unreachable state encodings -> LOW_STABLE, counter=0, with no pulse.
//  Reset mid-debounce: any pending change is discarded; outputs return to reset values immediately.
//  Button held through reset release: after 2+DEBOUNCE_CYCLES cycles, one press_pulse is generated.
// STRUCTURE
//  Shared package/header btn_pkg: FSM state localparams (LOW_STABLE=2'd0, LOW_WAIT=2'd1,
//   HIGH_STABLE=2'd2, HIGH_WAIT=2'd3) and the default DEBOUNCE_CYCLES for 12 MHz.
//  One sub-module: sync_2ff (generic 2-flop synchroniser, CLK/RST_N, 1-bit), reused for other pads.
//  FSM, counter, pulse generation, press counter and LED register live in this module.
// TESTING  (bench overrides DEBOUNCE_CYCLES=4, PCOUNT_W=3; CLK period 83.33 ns)
//  1 Reset: RST_N=0 with button=1 -> all outputs 0. Release RST_N and hold button=1
//    -> press_pulse exactly once, 6 cycles after release; press_count=1.
//  2 Bounce: button toggles 1,0,1,0 on successive cycles, then 1 held
//    -> no pulse during bounce; one press_pulse 6 cycles after the last 0->1; button_clean=1.
//  3 Glitch: 3-cycle high pulse on button from a low stable state
//    -> no pulse, button_clean stays 0, press_count unchanged.
//  4 Toggle mode: 3 clean press/release cycles (each level held 10 cycles)
//    -> EXTERNAL_LED goes 0->1->0->1; 3 release_pulses; press_count=3.
//  5 Wrap: 9 clean presses with PCOUNT_W=3 -> press_count reads 1 after the 9th press.
//  6 Async reset mid-debounce: assert RST_N=0 two cycles into HIGH_WAIT
//    -> outputs clear in the same cycle with no clock edge needed; no release_pulse is ever emitted.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the button debounce front end: FSM state encoding
// and the default debounce window for a 12 MHz system clock.
package btn_pkg;

  typedef enum logic [1:0] {
    LOW_STABLE  = 2'd0,
    LOW_WAIT    = 2'd1,
    HIGH_STABLE = 2'd2,
    HIGH_WAIT   = 2'd3
  } btn_state_e;

  // 10 ms at 12 MHz
  localparam int DEBOUNCE_CYCLES_12MHZ = 120000;

  // Debounce counter width needed to hold DEBOUNCE_CYCLES-1.
  function automatic int min_cnt_w(input int cycles);
    int w;
    w = 1;
    while ((2 ** w) <= cycles) w++;
    return w;
  endfunction

endpackage : btn_pkg

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for a single asynchronous pad signal.
// Only q_o may be used downstream; the first flop may go metastable.
module sync_2ff (
  input  logic CLK,
  input  logic RST_N,
  input  logic d_i,
  output logic q_o
);

  logic s0_q;
  logic s1_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s0_q <= 1'b0;
      s1_q <= 1'b0;
    end else begin
      s0_q <= d_i;
      s1_q <= s0_q;
    end
  end

  assign q_o = s1_q;

endmodule : sync_2ff

// File: rtl/button_debounce_led.sv
// Button front end: synchronise the raw pad, debounce with a 4-state FSM,
// emit press/release pulses, count presses and drive the external LED.
module button_debounce_led
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_12MHZ,
  parameter int CNT_W           = 17,
  parameter int LED_MODE        = 1,
  parameter int PCOUNT_W        = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                button,
  output logic                button_clean,
  output logic                press_pulse,
  output logic                release_pulse,
  output logic [PCOUNT_W-1:0] press_count,
  output logic                EXTERNAL_LED
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic                btn_s1;

  btn_state_e          state_q,   state_d;
  logic [CNT_W-1:0]    cnt_q,     cnt_d;
  logic                clean_q,   clean_d;
  logic                press_q,   press_d;
  logic                release_q, release_d;
  logic [PCOUNT_W-1:0] pcount_q,  pcount_d;
  logic                led_q,     led_d;

  sync_2ff u_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d_i   (button),
    .q_o   (btn_s1)
  );

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= LOW_STABLE;
      cnt_q     <= '0;
      clean_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      pcount_q  <= '0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      clean_q   <= clean_d;
      press_q   <= press_d;
      release_q <= release_d;
      pcount_q  <= pcount_d;
      led_q     <= led_d;
    end
  end

  // Counter holds the number of consecutive samples of the candidate level
  // seen so far; it returns to zero on any state change or opposite sample.
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    clean_d   = clean_q;
    press_d   = 1'b0;
    release_d = 1'b0;

    unique case (state_q)
      LOW_STABLE: begin
        if (btn_s1) begin
          state_d = LOW_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      LOW_WAIT: begin
        if (!btn_s1) begin
          state_d = LOW_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HIGH_STABLE;
          clean_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      HIGH_STABLE: begin
        if (!btn_s1) begin
          state_d = HIGH_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      HIGH_WAIT: begin
        if (btn_s1) begin
          state_d = HIGH_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = LOW_STABLE;
          clean_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = LOW_STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Press counter steps together with the press pulse; LED lags by one cycle.
  always_comb begin
    pcount_d = pcount_q;
    if (press_d) begin
      pcount_d = pcount_q + PCOUNT_W'(1);
    end

    led_d = led_q;
    if (LED_MODE == 0) begin
      led_d = clean_q;
    end else if (press_q) begin
      led_d = ~led_q;
    end
  end

  assign button_clean  = clean_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign press_count   = pcount_q;
  assign EXTERNAL_LED  = led_q;

endmodule : button_debounce_led

// File: tb/tb_button_debounce_led.sv
// Directed + randomized bench for button_debounce_led with a run-length
// reference model of the synchroniser and debouncer.
`timescale 1ns/1ps
module tb_button_debounce_led;

  localparam int D  = 4;
  localparam int PW = 3;

  logic          CLK;
  logic          RST_N;
  logic          button;

  logic          clean1, press1, rel1, led1;
  logic [PW-1:0] cnt1;
  logic          clean0, press0, rel0, led0;
  logic [PW-1:0] cnt0;

  int checks = 0;
  int errors = 0;
  int n_press = 0;
  int n_rel = 0;

  // Reference model state
  logic m_s0, m_s1, m_clean, m_press, m_rel, m_led, m_led0;
  int   m_run, m_cnt;

  button_debounce_led #(.DEBOUNCE_CYCLES(D), .CNT_W(17), .LED_MODE(1), .PCOUNT_W(PW)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .button(button),
    .button_clean(clean1), .press_pulse(press1), .release_pulse(rel1),
    .press_count(cnt1), .EXTERNAL_LED(led1)
  );

  button_debounce_led #(.DEBOUNCE_CYCLES(D), .CNT_W(17), .LED_MODE(0), .PCOUNT_W(PW)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .button(button),
    .button_clean(clean0), .press_pulse(press0), .release_pulse(rel0),
    .press_count(cnt0), .EXTERNAL_LED(led0)
  );

  initial CLK = 1'b0;
  always #41.665 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_s0 = 0; m_s1 = 0; m_clean = 0; m_press = 0; m_rel = 0;
    m_led = 0; m_led0 = 0; m_run = 0; m_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".clean"},  8'(clean1), 8'(m_clean));
    chk({tag, ".press"},  8'(press1), 8'(m_press));
    chk({tag, ".rel"},    8'(rel1),   8'(m_rel));
    chk({tag, ".count"},  8'(cnt1),   8'(m_cnt));
    chk({tag, ".led"},    8'(led1),   8'(m_led));
    chk({tag, ".clean0"}, 8'(clean0), 8'(m_clean));
    chk({tag, ".press0"}, 8'(press0), 8'(m_press));
    chk({tag, ".rel0"},   8'(rel0),   8'(m_rel));
    chk({tag, ".count0"}, 8'(cnt0),   8'(m_cnt));
    chk({tag, ".led0"},   8'(led0),   8'(m_led0));
  endtask

  // A change is accepted once D consecutive synchronised samples differ from
  // the clean level; the pad reaches the debouncer two clocks late.
  task automatic tick(input string tag);
    logic v;
    @(posedge CLK);
    if (RST_N) begin
      v      = m_s1;
      m_s1   = m_s0;
      m_s0   = button;
      m_led0 = m_clean;
      m_led  = m_led ^ m_press;
      m_press = 0;
      m_rel   = 0;
      if (v != m_clean) begin
        m_run++;
        if (m_run == D) begin
          m_clean = v;
          m_run   = 0;
          if (v) begin
            m_press = 1;
            m_cnt   = (m_cnt + 1) % (1 << PW);
          end else begin
            m_rel = 1;
          end
        end
      end else begin
        m_run = 0;
      end
    end
    #1;
    if (press1) n_press++;
    if (rel1)   n_rel++;
    check_all(tag);
  endtask

  task automatic press_release(input int hold);
    button = 1'b1;
    repeat (hold) tick("pr_hi");
    button = 1'b0;
    repeat (hold) tick("pr_lo");
  endtask

  initial begin
    int lat;
    int p0, r0;
    logic [1:0] pat;

    // 1: reset with button held high, then release
    RST_N  = 1'b0;
    button = 1'b1;
    model_reset();
    #100;
    check_all("t1_rst");
    tick("t1_inrst");
    tick("t1_inrst");
    RST_N = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick("t1_run");
      if (press1) begin
        lat = i;
        break;
      end
    end
    chk("t1_latency", 8'(lat), 8'd6);
    repeat (10) tick("t1_hold");
    chk("t1_npress", 8'(n_press), 8'd1);
    chk("t1_count", 8'(cnt1), 8'd1);

    // 2: bounce 1,0,1,0 then held high
    button = 1'b0;
    repeat (10) tick("t2_low");
    p0 = n_press;
    pat = 2'b00;
    for (int i = 0; i < 4; i++) begin
      button = ~i[0];
      tick("t2_bounce");
    end
    button = 1'b1;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      tick("t2_run");
      if (press1) begin
        lat = i;
        break;
      end
    end
    chk("t2_latency", 8'(lat), 8'd6);
    chk("t2_npress", 8'(n_press - p0), 8'd1);
    chk("t2_clean", 8'(clean1), 8'd1);
    repeat (5) tick("t2_hold");

    // 3: 3-cycle glitch from low stable
    button = 1'b0;
    repeat (10) tick("t3_low");
    p0 = n_press;
    button = 1'b1;
    repeat (3) tick("t3_glitch");
    button = 1'b0;
    repeat (10) tick("t3_after");
    chk("t3_npress", 8'(n_press - p0), 8'd0);
    chk("t3_clean", 8'(clean1), 8'd0);
    chk("t3_count", 8'(cnt1), 8'd2);

    // 4: toggle mode, three clean press/release cycles
    chk("t4_led_start", 8'(led1), 8'd0);
    r0 = n_rel;
    button = 1'b1; repeat (10) tick("t4");
    chk("t4_led_p1", 8'(led1), 8'd1);
    button = 1'b0; repeat (10) tick("t4");
    chk("t4_led_r1", 8'(led1), 8'd1);
    button = 1'b1; repeat (10) tick("t4");
    chk("t4_led_p2", 8'(led1), 8'd0);
    button = 1'b0; repeat (10) tick("t4");
    button = 1'b1; repeat (10) tick("t4");
    chk("t4_led_p3", 8'(led1), 8'd1);
    button = 1'b0; repeat (10) tick("t4");
    chk("t4_nrel", 8'(n_rel - r0), 8'd3);
    chk("t4_count", 8'(cnt1), 8'd5);

    // 5: press counter wrap after 9 presses
    RST_N = 1'b0;
    #1;
    model_reset();
    tick("t5_rst");
    RST_N = 1'b1;
    repeat (8) press_release(10);
    chk("t5_count8", 8'(cnt1), 8'd0);
    button = 1'b1;
    repeat (10) tick("t5_9th");
    chk("t5_count9", 8'(cnt1), 8'd1);

    // 6: async reset two cycles into HIGH_WAIT
    button = 1'b0;
    repeat (4) tick("t6_wait");
    #20;
    RST_N = 1'b0;
    #1;
    model_reset();
    check_all("t6_async");
    r0 = n_rel;
    repeat (3) tick("t6_inrst");
    RST_N = 1'b1;
    repeat (20) tick("t6_after");
    chk("t6_nrel", 8'(n_rel - r0), 8'd0);

    // Randomized hold lengths around the debounce window
    for (int i = 0; i < 80; i++) begin
      button = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 8)) tick("rand");
    end
    button = 1'b0;
    repeat (10) tick("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_button_debounce_led
